// File: rtl/axis_fifo_param.sv
// Parametrised first-word-fall-through AXI-Stream FIFO with fill-level reporting.
// Define AXIS_FIFO_PKT_EN to hold output until a complete packet is stored (store-and-forward).
module axis_fifo_param #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic              m_last,
    output logic [DATA_W-1:0] s_data,
    output logic              s_valid,
    input  logic              s_ready,
    output logic              s_last,
    output logic [CNT_W-1:0]  level,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W:0]      mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     level_r;
    logic                 wr_en;
    logic                 rd_en;
    logic [DATA_W:0]      head;

    assign full    = (level_r == CNT_W'(DEPTH));
    assign empty   = (level_r == '0);
    assign level   = level_r;
    // Gate with rst so upstream sees back-pressure for the whole reset interval.
    assign m_ready = !full && !rst;
    assign wr_en   = m_valid && m_ready;
    assign rd_en   = s_valid && s_ready;
    assign head    = mem[rd_ptr];
    assign s_data  = s_valid ? head[DATA_W-1:0] : '0;
    assign s_last  = s_valid ? head[DATA_W] : 1'b0;

`ifdef AXIS_FIFO_PKT_EN
    logic [CNT_W-1:0] pkt_cnt;
    logic             pkt_inc;
    logic             pkt_dec;

    assign pkt_inc = wr_en && m_last;
    assign pkt_dec = rd_en && s_last;
    // A full FIFO with no complete packet would deadlock; let it cut through instead.
    assign s_valid = !empty && ((pkt_cnt != '0) || full);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else begin
            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end
`else
    assign s_valid = !empty;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_r <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   level_r <= level_r + 1'b1;
                2'b01:   level_r <= level_r - 1'b1;
                default: level_r <= level_r;
            endcase
        end
    end

    // Storage carries no reset; contents are only observable once written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {m_last, data_in};
        end
    end

endmodule
